// File: rtl/display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : display_sequencer
// Description : Resets and initialises an SPI OLED panel, then streams
//               1024-byte frames (8 pages x 128 columns) without gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module display_sequencer #(
    parameter int CLK_DIV      = 2,
    parameter int RESET_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    output logic [2:0] row,
    output logic [6:0] col,
    output logic [2:0] place,
    output logic       dc,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       res_n,
    output logic       frame_done
);

    localparam logic [7:0]  c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_RST_LAST = 16'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RST_WAIT = 2'd1,
        CMD      = 2'd2,
        STREAM   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_cnt;
    logic [7:0]  r_div;
    logic [2:0]  r_bit;
    logic [2:0]  r_cmd_idx;
    logic [6:0]  r_rest;
    logic        r_load;

    logic [2:0]  r_row;
    logic [6:0]  r_col;
    logic [2:0]  r_place;
    logic        r_dc;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_res_n;
    logic        r_frame_done;

    logic        w_phase_end;
    logic        w_tick;
    logic        w_bit_end;
    logic        w_byte_end;
    logic        w_last_cmd;
    logic [2:0]  w_rom_idx;
    logic [7:0]  w_rom_byte;

    function automatic logic [7:0] f_cmd_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    f_cmd_rom = 8'hAE;
            3'd1:    f_cmd_rom = 8'h8D;
            3'd2:    f_cmd_rom = 8'h14;
            3'd3:    f_cmd_rom = 8'h20;
            3'd4:    f_cmd_rom = 8'h00;
            3'd5:    f_cmd_rom = 8'hA1;
            3'd6:    f_cmd_rom = 8'hC8;
            default: f_cmd_rom = 8'hAF;
        endcase
    endfunction

    assign w_phase_end = (r_cnt == c_RST_LAST);
    assign w_tick      = (r_div == c_DIV_LAST);
    assign w_bit_end   = w_tick && r_sclk;
    assign w_byte_end  = w_bit_end && (r_bit == 3'd7);
    assign w_last_cmd  = (r_cmd_idx == 3'd7);
    assign w_rom_idx   = (r_state == CMD) ? (r_cmd_idx + 3'd1) : 3'd0;
    assign w_rom_byte  = f_cmd_rom(w_rom_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RST_HOLD: if (w_phase_end) w_state_nxt = RST_WAIT;
            RST_WAIT: if (w_phase_end) w_state_nxt = CMD;
            CMD:      if (w_byte_end && w_last_cmd) w_state_nxt = STREAM;
            default:  w_state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= 16'd0;
            r_div        <= 8'd0;
            r_bit        <= 3'd0;
            r_cmd_idx    <= 3'd0;
            r_rest       <= 7'd0;
            r_load       <= 1'b0;
            r_row        <= 3'd0;
            r_col        <= 7'd0;
            r_place      <= 3'd0;
            r_dc         <= 1'b0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_res_n      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                RST_HOLD: begin
                    r_cs_n <= 1'b1;
                    r_sclk <= 1'b0;
                    r_mosi <= 1'b0;
                    r_dc   <= 1'b0;
                    if (w_phase_end) begin
                        r_cnt   <= 16'd0;
                        r_res_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RST_WAIT: begin
                    if (w_phase_end) begin
                        // First command bit must already be on the line as cs_n falls
                        r_cnt     <= 16'd0;
                        r_cs_n    <= 1'b0;
                        r_cmd_idx <= 3'd0;
                        r_rest    <= w_rom_byte[6:0];
                        r_mosi    <= w_rom_byte[7];
                        r_div     <= 8'd0;
                        r_sclk    <= 1'b0;
                        r_bit     <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_div <= w_tick ? 8'd0 : (r_div + 8'd1);
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_bit_end) begin
                        if (r_bit != 3'd7) begin
                            r_bit  <= r_bit + 3'd1;
                            r_mosi <= r_rest[6];
                            r_rest <= {r_rest[5:0], 1'b0};
                            if (r_state == STREAM) begin
                                r_place <= r_bit + 3'd1;
                            end
                        end else begin
                            r_bit <= 3'd0;
                            if (r_state == CMD) begin
                                if (w_last_cmd) begin
                                    r_dc   <= 1'b1;
                                    r_load <= 1'b1;
                                end else begin
                                    r_cmd_idx <= r_cmd_idx + 3'd1;
                                    r_rest    <= w_rom_byte[6:0];
                                    r_mosi    <= w_rom_byte[7];
                                end
                            end else begin
                                // Address wraps naturally at page 7 / column 127
                                r_place <= 3'd0;
                                r_load  <= 1'b1;
                                r_col   <= r_col + 7'd1;
                                if (r_col == 7'd127) begin
                                    r_row <= r_row + 3'd1;
                                end
                                if ((r_row == 3'd7) && (r_col == 7'd127)) begin
                                    r_frame_done <= 1'b1;
                                end
                            end
                        end
                    end
                    // Pixel data is only valid once row/col show the new byte,
                    // so the MSB is captured at the end of the byte's first cycle.
                    if (r_load) begin
                        r_rest <= data[6:0];
                        r_mosi <= data[7];
                        r_load <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign row        = r_row;
    assign col        = r_col;
    assign place      = r_place;
    assign dc         = r_dc;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign cs_n       = r_cs_n;
    assign res_n      = r_res_n;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_sequencer
// Description : Cycle-level reference model of the panel sequencer timeline.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_display_sequencer;

    localparam int CLK_DIV      = 2;
    localparam int RESET_CYCLES = 4;
    localparam int BIT_CYC      = 2 * CLK_DIV;
    localparam int BYTE_CYC     = 8 * BIT_CYC;
    localparam int CMD_CYC      = 8 * BYTE_CYC;
    localparam int FRAME_CYC    = 1024 * BYTE_CYC;
    localparam int INIT_CYC     = 2 * RESET_CYCLES - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic [2:0] row;
    logic [6:0] col;
    logic [2:0] place;
    logic       dc, sclk, mosi, cs_n, res_n, frame_done;

    display_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .row        (row),
        .col        (col),
        .place      (place),
        .dc         (dc),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .res_n      (res_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         k       = -1;   // edges since reset release, -1 while held
    logic [7:0] exp_byte = 8'h00;
    logic [7:0] rom [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [2:0] e_row, e_place;
        logic [6:0] e_col;
        logic       e_dc, e_sclk, e_mosi, e_cs_n, e_res_n, e_fd, mosi_valid;
        logic [7:0] cur;
        int         s, u, p, n;
        e_row = 0; e_col = 0; e_place = 0; e_dc = 0; e_sclk = 0; e_mosi = 0;
        e_cs_n = 1; e_res_n = 0; e_fd = 0; mosi_valid = 1;
        if (k < RESET_CYCLES - 1) begin
            e_res_n = 0;
        end else if (k < INIT_CYC) begin
            e_res_n = 1;
        end else begin
            s = k - INIT_CYC;
            e_res_n = 1;
            e_cs_n  = 0;
            if (s < CMD_CYC) begin
                p      = s % BYTE_CYC;
                e_sclk = (p % BIT_CYC) >= CLK_DIV;
                cur    = rom[s / BYTE_CYC];
                e_mosi = cur[7 - p / BIT_CYC];
            end else begin
                u       = s - CMD_CYC;
                n       = (u / BYTE_CYC) % 1024;
                p       = u % BYTE_CYC;
                e_dc    = 1;
                e_row   = 3'(n / 128);
                e_col   = 7'(n % 128);
                e_place = 3'(p / BIT_CYC);
                e_sclk  = (p % BIT_CYC) >= CLK_DIV;
                e_fd    = (u > 0) && (u % FRAME_CYC == 0);
                if (p == 0) mosi_valid = 0;
                else        e_mosi = exp_byte[7 - p / BIT_CYC];
            end
        end
        check("ctrl dc/sclk/cs_n/res_n/frame_done",
              32'({dc, sclk, cs_n, res_n, frame_done}),
              32'({e_dc, e_sclk, e_cs_n, e_res_n, e_fd}));
        check("addr row/col/place", 32'({row, col, place}), 32'({e_row, e_col, e_place}));
        if (mosi_valid) check("mosi", 32'(mosi), 32'(e_mosi));
    endtask

    task automatic drive_data();
        int u;
        if (k >= INIT_CYC + CMD_CYC) begin
            u = k - INIT_CYC - CMD_CYC;
            if (u % BYTE_CYC == 0) begin
                data     = ((u / BYTE_CYC) % 1024 < 2) ? 8'hA5 : 8'($urandom);
                exp_byte = data;
            end else begin
                data = ($urandom_range(0, 1) == 1) ? ~exp_byte : 8'($urandom);
            end
        end else begin
            data = 8'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) k++;
            else       k = -1;
            #1;
            check_cycle();
            drive_data();
        end
    endtask

    initial begin
        rom[0] = 8'hAE; rom[1] = 8'h8D; rom[2] = 8'h14; rom[3] = 8'h20;
        rom[4] = 8'h00; rom[5] = 8'hA1; rom[6] = 8'hC8; rom[7] = 8'hAF;
        rst_n = 1'b0;
        data  = 8'h00;
        run(3);
        rst_n = 1'b1;
        // Through one complete frame wrap, stopping partway into a byte
        run(INIT_CYC + CMD_CYC + FRAME_CYC + 2 * BYTE_CYC + $urandom_range(1, 30));
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(INIT_CYC + CMD_CYC + 130 * BYTE_CYC);
        for (int r = 0; r < 3; r++) begin
            run($urandom_range(1, INIT_CYC + CMD_CYC + 200));
            rst_n = 1'b0;
            run($urandom_range(1, 3));
            rst_n = 1'b1;
            run(INIT_CYC + CMD_CYC + 3 * BYTE_CYC);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
